// File: rtl/demux12_stream_pkg.sv
// -----------------------------------------------------------------------------
// demux12_stream_pkg
// Shared constants for the 1:2 word stream demultiplexer.
//   lane_e      : lane pointer encoding (LANE_A = 0, LANE_B = 1)
//   PAIR_CNT_W  : width of the completed-pair counter
//   lane_flip() : next lane after a valid word
// -----------------------------------------------------------------------------
package demux12_stream_pkg;

   typedef enum logic {
      LANE_A = 1'b0,
      LANE_B = 1'b1
   } lane_e;

   localparam int PAIR_CNT_W = 8;

   function automatic lane_e lane_flip(input lane_e l);
      return (l == LANE_A) ? LANE_B : LANE_A;
   endfunction

endpackage

// File: rtl/demux12_stream_lane_reg.sv
// -----------------------------------------------------------------------------
// demux_lane_reg
// WIDTH-bit data register with load enable and asynchronous active-low clear.
// Ports:
//   clk      : clock, rising edge
//   reset_L  : asynchronous active-low clear (register -> 0)
//   load     : capture d on the next rising edge
//   d        : data in
//   q        : registered data out, holds when load is low
// -----------------------------------------------------------------------------
module demux_lane_reg #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/demux12_stream.sv
// -----------------------------------------------------------------------------
// demux12_stream
// Splits a serial word stream (output of a 2:1 word mux) back into two lanes.
// Valid words alternate A, B, A, B ... starting from START_LANE after reset;
// every B word that follows an A word completes a pair.
// Ports:
//   clk        : clock, rising edge
//   reset_L    : asynchronous active-low reset
//   in_data    : serial word stream (don't-care while in_valid is low)
//   in_valid   : in_data holds a valid word this cycle
//   out_A      : registered lane-A word, holds between updates
//   valid_A    : one-cycle pulse, out_A updated this cycle
//   out_B      : registered lane-B word, holds between updates
//   valid_B    : one-cycle pulse, out_B updated this cycle
//   pair_done  : one-cycle pulse, a lane-B word completed a pair
//   pair_count : completed pairs since reset, wraps modulo 2**PAIR_CNT_W
// -----------------------------------------------------------------------------
module demux12_stream
   import demux12_stream_pkg::*;
#(
   parameter int WIDTH      = 2,
   parameter int START_LANE = 0
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic [WIDTH-1:0]      in_data,
   input  logic                  in_valid,
   output logic [WIDTH-1:0]      out_A,
   output logic                  valid_A,
   output logic [WIDTH-1:0]      out_B,
   output logic                  valid_B,
   output logic                  pair_done,
   output logic [PAIR_CNT_W-1:0] pair_count
);

   localparam lane_e RST_LANE = (START_LANE == 0) ? LANE_A : LANE_B;

   lane_e lane;
   lane_e lane_next;
   logic  load_a;
   logic  load_b;

   // Lane pointer state register.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         lane <= RST_LANE;
      end else begin
         lane <= lane_next;
      end
   end

   // Steering decode; nothing loads while in_valid is low, so in_data
   // (including X) cannot reach any output in that case.
   always_comb begin
      lane_next = lane;
      load_a    = 1'b0;
      load_b    = 1'b0;
      if (in_valid) begin
         lane_next = lane_flip(lane);
         if (lane == LANE_A) begin
            load_a = 1'b1;
         end else begin
            load_b = 1'b1;
         end
      end
   end

   // Valid pulses and pair counter. A pair completes only on a B word, so
   // a leading B word with START_LANE=1 also counts... only if an A word
   // preceded it: the first B after reset has no A partner and is excluded.
   logic seen_a;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         valid_A    <= 1'b0;
         valid_B    <= 1'b0;
         pair_done  <= 1'b0;
         pair_count <= '0;
         seen_a     <= 1'b0;
      end else begin
         valid_A   <= load_a;
         valid_B   <= load_b;
         pair_done <= load_b && seen_a;
         if (load_a) begin
            seen_a <= 1'b1;
         end
         if (load_b && seen_a) begin
            pair_count <= pair_count + PAIR_CNT_W'(1);
         end
      end
   end

   demux_lane_reg #(.WIDTH(WIDTH)) u_lane_a (
      .clk     (clk),
      .reset_L (reset_L),
      .load    (load_a),
      .d       (in_data),
      .q       (out_A)
   );

   demux_lane_reg #(.WIDTH(WIDTH)) u_lane_b (
      .clk     (clk),
      .reset_L (reset_L),
      .load    (load_b),
      .d       (in_data),
      .q       (out_B)
   );

endmodule

// File: tb/tb_demux12_stream.sv
// -----------------------------------------------------------------------------
// tb_demux12_stream
// Two instances share clock, reset and input stream: dut0 starts on lane A,
// dut1 starts on lane B. A word-count reference model predicts every output
// of both instances after each clock.
// -----------------------------------------------------------------------------
module tb_demux12_stream;

   localparam int W = 2;

   logic         clk = 1'b0;
   logic         reset_L = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;

   logic [W-1:0] a0, b0, a1, b1;
   logic         va0, vb0, pd0, va1, vb1, pd1;
   logic [7:0]   pc0, pc1;

   always #5 clk = ~clk;

   demux12_stream #(.WIDTH(W), .START_LANE(0)) dut0 (
      .clk(clk), .reset_L(reset_L), .in_data(in_data), .in_valid(in_valid),
      .out_A(a0), .valid_A(va0), .out_B(b0), .valid_B(vb0),
      .pair_done(pd0), .pair_count(pc0)
   );

   demux12_stream #(.WIDTH(W), .START_LANE(1)) dut1 (
      .clk(clk), .reset_L(reset_L), .in_data(in_data), .in_valid(in_valid),
      .out_A(a1), .valid_A(va1), .out_B(b1), .valid_B(vb1),
      .pair_done(pd1), .pair_count(pc1)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: the lane of a word is (start + words since reset) mod 2;
   // a pair completes on a B word that has an earlier A word since reset.
   int         m_start[2] = '{0, 1};
   int         m_words[2];
   int         m_awords[2];
   logic [W-1:0] m_a[2], m_b[2];
   bit         m_va[2], m_vb[2], m_pd[2];
   int         m_cnt[2];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_words[i] = 0; m_awords[i] = 0;
         m_a[i] = '0; m_b[i] = '0;
         m_va[i] = 0; m_vb[i] = 0; m_pd[i] = 0; m_cnt[i] = 0;
      end
   endfunction

   function automatic void model_clock(input bit v, input logic [W-1:0] d);
      for (int i = 0; i < 2; i++) begin
         m_va[i] = 0; m_vb[i] = 0; m_pd[i] = 0;
         if (v) begin
            if ((m_start[i] + m_words[i]) % 2 == 0) begin
               m_a[i] = d; m_va[i] = 1; m_awords[i]++;
            end else begin
               m_b[i] = d; m_vb[i] = 1;
               if (m_awords[i] > 0) begin
                  m_pd[i] = 1;
                  m_cnt[i] = (m_cnt[i] + 1) % 256;
               end
            end
            m_words[i]++;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".d0.out_A"},   32'(a0),  32'(m_a[0]));
      chk({tag, ".d0.valid_A"}, 32'(va0), 32'(m_va[0]));
      chk({tag, ".d0.out_B"},   32'(b0),  32'(m_b[0]));
      chk({tag, ".d0.valid_B"}, 32'(vb0), 32'(m_vb[0]));
      chk({tag, ".d0.pair_done"},  32'(pd0), 32'(m_pd[0]));
      chk({tag, ".d0.pair_count"}, 32'(pc0), 32'(m_cnt[0]));
      chk({tag, ".d1.out_A"},   32'(a1),  32'(m_a[1]));
      chk({tag, ".d1.valid_A"}, 32'(va1), 32'(m_va[1]));
      chk({tag, ".d1.out_B"},   32'(b1),  32'(m_b[1]));
      chk({tag, ".d1.valid_B"}, 32'(vb1), 32'(m_vb[1]));
      chk({tag, ".d1.pair_done"},  32'(pd1), 32'(m_pd[1]));
      chk({tag, ".d1.pair_count"}, 32'(pc1), 32'(m_cnt[1]));
      chk({tag, ".d0.onehot"}, 32'(va0 & vb0), 32'd0);
      chk({tag, ".d1.onehot"}, 32'(va1 & vb1), 32'd0);
   endtask

   // One clock: drive inputs, advance model at the edge, check 1 time unit later.
   task automatic step(input string tag, input bit v, input logic [W-1:0] d);
      in_valid = v;
      in_data  = v ? d : W'($urandom);
      @(posedge clk);
      model_clock(v, d);
      #1;
      check_all(tag);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_L = 1'b0;
      model_reset();
      #1;
      check_all("reset");
      @(negedge clk);
      reset_L = 1'b1;
   endtask

   logic [W-1:0] src_a[$], src_b[$], rx_a[$], rx_b[$];
   int pd_pulses;

   initial begin
      model_reset();
      #2;
      check_all("por");
      do_reset();

      // Four back-to-back words: 01 10 11 00.
      step("b2b0", 1, 2'b01);
      step("b2b1", 1, 2'b10);
      step("b2b2", 1, 2'b11);
      step("b2b3", 1, 2'b00);
      chk("b2b.pair_count", 32'(pc0), 32'd2);
      step("b2b_idle", 0, 2'b00);

      // Gap between words; out_A must hold.
      do_reset();
      step("gap0", 1, 2'b01);
      step("gap1", 0, 2'b00);
      step("gap2", 1, 2'b10);
      chk("gap.hold_A", 32'(a0), 32'd1);

      // Start-lane-B behaviour on dut1: words 10, 01.
      do_reset();
      step("sl1_0", 1, 2'b10);
      chk("sl1.first_to_B", 32'(b1), 32'd2);
      chk("sl1.no_pair", 32'(pd1), 32'd0);
      step("sl1_1", 1, 2'b01);
      chk("sl1.second_to_A", 32'(a1), 32'd1);
      chk("sl1.count", 32'(pc1), 32'd0);

      // Asynchronous reset in the middle of a cycle after one A word.
      do_reset();
      step("mid0", 1, 2'b10);
      #2;
      reset_L = 1'b0;
      model_reset();
      #1;
      check_all("async_clear");
      chk("async.out_A", 32'(a0), 32'd0);
      @(negedge clk);
      reset_L = 1'b1;
      step("mid_after", 1, 2'b11);
      chk("mid_after.out_A", 32'(a0), 32'd3);

      // 512 consecutive valid words: counter wraps after 256 pairs.
      do_reset();
      pd_pulses = 0;
      for (int i = 0; i < 512; i++) begin
         step("wrap", 1, W'($urandom));
         if (pd0) pd_pulses++;
      end
      chk("wrap.pair_count", 32'(pc0), 32'd0);
      chk("wrap.pulses", 32'(pd_pulses), 32'd256);

      // Loopback through a 2:1 word mux with random idle gaps.
      do_reset();
      for (int i = 0; i < 50; i++) begin
         src_a.push_back(W'($urandom));
         src_b.push_back(W'($urandom));
      end
      for (int i = 0; i < 100; i++) begin
         while ($urandom_range(0, 3) == 0) begin
            step("loop_gap", 0, 2'b00);
         end
         step("loop", 1, (i % 2 == 0) ? src_a[i/2] : src_b[i/2]);
         if (va0) rx_a.push_back(a0);
         if (vb0) rx_b.push_back(b0);
      end
      chk("loop.len_A", 32'(rx_a.size()), 32'd50);
      chk("loop.len_B", 32'(rx_b.size()), 32'd50);
      for (int i = 0; i < 50 && i < rx_a.size() && i < rx_b.size(); i++) begin
         chk("loop.A", 32'(rx_a[i]), 32'(src_a[i]));
         chk("loop.B", 32'(rx_b[i]), 32'(src_b[i]));
      end
      chk("loop.pairs", 32'(pc0), 32'd50);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux12_stream.md
DEMUX12_STREAM -- requirements
Module: demux12_stream

Interface
REQ-001 Parameter WIDTH, default 2, bit width of each data word.
REQ-002 Parameter START_LANE, default 0, lane that receives the first valid word after reset (0 = lane A, 1 = lane B).
REQ-003 clk  input  1  single clock, all state updates on posedge.
REQ-004 reset_L  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  WIDTH  serial word stream, the output of the team's 2:1 word mux.
REQ-006 in_valid  input  1  in_data holds a valid word this cycle.
REQ-007 out_A  output  WIDTH  registered lane-A word.
REQ-008 valid_A  output  1  out_A updated this cycle; one-cycle pulse.
REQ-009 out_B  output  WIDTH  registered lane-B word.
REQ-010 valid_B  output  1  out_B updated this cycle; one-cycle pulse.
REQ-011 pair_done  output  1  one-cycle pulse; a lane-B word completed an A/B pair.
REQ-012 pair_count  output  8  number of completed pairs since reset, modulo 256.

Function
REQ-013 Internal 1-bit lane pointer `lane`; state 0 = LANE_A, state 1 = LANE_B.
REQ-014 Posedge clk with in_valid=1, lane=0: out_A <= in_data, valid_A <= 1, lane <= 1.
REQ-015 Posedge clk with in_valid=1, lane=1: out_B <= in_data, valid_B <= 1, lane <= 0, pair_done <= 1.
REQ-016 Posedge clk with in_valid=1, lane=1: pair_count <= pair_count+1.
REQ-017 Posedge clk with in_valid=0: valid_A, valid_B and pair_done <= 0; out_A, out_B, lane and pair_count hold.
REQ-018 Latency is exactly one clock from an in_valid word to its valid_A/valid_B pulse; no bubbles, back-to-back words accepted every cycle.
REQ-019 valid_A and valid_B are never high in the same cycle.
REQ-020 The non-selected lane's data output holds its previous value.
REQ-021 pair_count wraps from 255 to 0 with no flag.
REQ-022 A pair completes (REQ-015/REQ-016) only on the transition lane 1 -> 0, even when START_LANE=1.
REQ-023 With START_LANE=1, the first word goes to lane B and does not complete a pair.
REQ-024 in_data is don't-care while in_valid=0; X on in_data with in_valid=0 does not propagate to any output.

Reset
REQ-025 reset_L low asynchronously forces out_A=0, out_B=0, valid_A=0, valid_B=0, pair_done=0, pair_count=0 and lane=START_LANE, independent of clk.
REQ-026 Reset asserted mid-stream discards the partial pair; the first valid word after release goes to START_LANE.
REQ-027 A word presented on the first posedge after reset_L rises is accepted normally.

Structure
REQ-028 LANE_A/LANE_B encodings and the pair_count width (8) are defined in the team's shared constants include file; they are not local literals.
REQ-029 One sub-module, demux_lane_reg, is natural: a WIDTH-bit register with load enable and async active-low clear; it is instantiated twice (lane A, lane B).
REQ-030 Pointer, valid and counter logic stay in the top module.
REQ-031 The block is synthesizable; it carries no # delays in its functional logic.

Verification
REQ-032 Reset, then in_valid=1 for 4 cycles with words 01, 10, 11, 00 -> out_A=01 then 11, out_B=10 then 00, alternating valid pulses, pair_done twice, pair_count=2.
REQ-033 Words 01, gap (in_valid=0), 10 -> valid_A on cycle 1, nothing on cycle 2, valid_B on cycle 3, out_A held at 01 throughout.
REQ-034 Assert reset_L low mid-clock after one lane-A word -> outputs clear immediately; next word 11 appears on out_A.
REQ-035 START_LANE=1, words 10, 01 -> out_B=10 first with no pair_done; then out_A=01; pair_count=0.
REQ-036 Drive 512 consecutive valid words -> pair_count wraps to 0 after 256 pairs; 256 pair_done pulses counted.
REQ-037 Loopback: the team's 2:1 word mux feeds this block; recovered lane streams equal the original in_A/in_B streams for a random 100-word sequence.
